// File: rtl/riscv_pipe_pkg.sv
// Shared fetch/decode pipeline types and constants.
package riscv_pipe_pkg;

  localparam int          IF_ID_XLEN = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;  // addi x0, x0, 0

  typedef struct packed {
    logic [IF_ID_XLEN-1:0] instr;
    logic [IF_ID_XLEN-1:0] pc;
    logic [IF_ID_XLEN-1:0] pcplus4;
  } if_id_payload_t;

endpackage

// File: rtl/fetch_decode_pipe_stage_sat_counter.sv
// Saturating up-counter used for the fetch/decode stall statistics.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_o <= '0;
    end else if (inc_i && (count_o != {WIDTH{1'b1}})) begin
      count_o <= count_o + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_decode_pipe_stage.sv
// Fetch->decode pipeline register with valid/ready handshake, flush and stall counter.
// Optional one-entry skid buffer with registered in_ready_o: define FETCH_DECODE_SKID_EN.
module fetch_decode_pipe_stage
  import riscv_pipe_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_WIDTH-1:0]      Instr_i,
  input  logic [DATA_WIDTH-1:0]      PC_i,
  input  logic [DATA_WIDTH-1:0]      PCPlus4_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_WIDTH-1:0]      Instr_o,
  output logic [DATA_WIDTH-1:0]      PC_o,
  output logic [DATA_WIDTH-1:0]      PCPlus4_o,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pcplus4;
  } payload_t;

  localparam logic [DATA_WIDTH-1:0] NOP_W = DATA_WIDTH'(NOP_INSTR);

  payload_t m_data;
  payload_t in_data;
  logic     m_valid;
  logic     accept;
  logic     consume;
  logic     m_load;

  assign in_data = '{instr: Instr_i, pc: PC_i, pcplus4: PCPlus4_i};
  assign accept  = in_valid_i & in_ready_o;
  assign consume = m_valid & out_ready_i;
  assign m_load  = ~m_valid | consume;

`ifdef FETCH_DECODE_SKID_EN
  payload_t s_data;
  logic     s_valid;

  // S only fills while M is stalled, so M is never empty while S holds data.
  assign in_ready_o = ~s_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '{instr: NOP_W, pc: '0, pcplus4: '0};
      s_valid <= 1'b0;
      s_data  <= '0;
    end else if (flush_i) begin
      m_valid      <= 1'b0;
      s_valid      <= 1'b0;
      m_data.instr <= NOP_W;
    end else if (m_load) begin
      if (s_valid) begin
        m_data  <= s_data;
        m_valid <= 1'b1;
        s_valid <= 1'b0;
      end else if (accept) begin
        m_data  <= in_data;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      s_data  <= in_data;
      s_valid <= 1'b1;
    end
  end
`else
  assign in_ready_o = ~m_valid | out_ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '{instr: NOP_W, pc: '0, pcplus4: '0};
    end else if (flush_i) begin
      m_valid      <= 1'b0;
      m_data.instr <= NOP_W;
    end else if (m_load) begin
      m_valid <= accept;
      if (accept) begin
        m_data <= in_data;
      end
    end
  end
`endif

  assign out_valid_o = m_valid;
  assign Instr_o     = m_data.instr;
  assign PC_o        = m_data.pc;
  assign PCPlus4_o   = m_data.pcplus4;

  sat_counter #(
    .WIDTH (STALL_CNT_WIDTH)
  ) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (m_valid & ~out_ready_i),
    .count_o (stall_cnt_o)
  );

endmodule

// File: tb/tb_fetch_decode_pipe_stage.sv
// Directed bench for fetch_decode_pipe_stage; adapts to FETCH_DECODE_SKID_EN.
module tb_fetch_decode_pipe_stage;

  localparam logic [31:0] NOP = 32'h00000013;
`ifdef FETCH_DECODE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr_in, pc_in, pc4_in, instr_out, pc_out, pc4_out;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_decode_pipe_stage #(
    .DATA_WIDTH      (32),
    .STALL_CNT_WIDTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .Instr_i     (instr_in),
    .PC_i        (pc_in),
    .PCPlus4_i   (pc4_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .Instr_o     (instr_out),
    .PC_o        (pc_out),
    .PCPlus4_o   (pc4_out),
    .stall_cnt_o (stall_cnt)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        exp_rdy;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [3:0]  exp_stall;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return 32'hA000_0000 | pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [31:0] pc, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    pc_in     = pc;
    instr_in  = instr_of(pc);
    pc4_in    = pc + 32'd4;
    out_ready = ordy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input logic nop);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, v});
    chk({tag, ".pc"}, pc_out, pc);
    chk({tag, ".pc4"}, pc4_out, pc + 32'd4);
    chk({tag, ".instr"}, instr_out, nop ? NOP : instr_of(pc));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, ".instr"}, instr_out, NOP);
    chk({tag, ".pc"}, pc_out, 32'd0);
    chk({tag, ".pc4"}, pc4_out, 32'd0);
    chk({tag, ".stall"}, {28'b0, stall_cnt}, 32'd0);
    chk({tag, ".in_ready"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    //            fl  iv  pc     ordy rdy   valid pc     stall
    vecs[0] = '{1'b0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 4'd0};
    vecs[1] = '{1'b0, 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 32'h4, 4'd0};
    vecs[2] = '{1'b0, 1'b1, 32'h8, 1'b1, 1'b1, 1'b1, 32'h8, 4'd0};
    vecs[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h8, 4'd0};
    vecs[4] = '{1'b0, 1'b1, 32'hC, 1'b0, 1'b1, 1'b1, 32'hC, 4'd0};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 1'b0, SKID, 1'b1, 32'hC, 4'd1};
    vecs[6] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'hC, 4'd1};

    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1 rst = 1'b1;
    #2 chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
      #1 chk($sformatf("vec%0d.in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_rdy});
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_pc, 1'b0);
      chk($sformatf("vec%0d.stall", i), {28'b0, stall_cnt}, {28'b0, vecs[i].exp_stall});
    end

    // flush while consuming and accepting: both entries vanish, PC held
    drive(1'b0, 1'b1, 32'h200, 1'b0);
    tick();
    chk_out("flush.pre", 1'b1, 32'h200, 1'b0);
    drive(1'b1, 1'b1, 32'h204, 1'b1);
    tick();
    chk_out("flush.post", 1'b0, 32'h200, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk_out("flush.idle", 1'b0, 32'h200, 1'b1);
    chk("flush.stall", {28'b0, stall_cnt}, 32'd1);

`ifdef FETCH_DECODE_SKID_EN
    drive(1'b0, 1'b1, 32'h100, 1'b0);
    #1 chk("skid.rdy0", {31'b0, in_ready}, 32'd1);
    tick();
    chk_out("skid.m100", 1'b1, 32'h100, 1'b0);
    drive(1'b0, 1'b1, 32'h104, 1'b0);
    #1 chk("skid.rdy1", {31'b0, in_ready}, 32'd1);
    tick();
    chk_out("skid.hold100", 1'b1, 32'h100, 1'b0);
    chk("skid.rdy_full", {31'b0, in_ready}, 32'd0);
    drive(1'b0, 1'b1, 32'h108, 1'b0);
    tick();
    chk_out("skid.block108", 1'b1, 32'h100, 1'b0);
    drive(1'b0, 1'b1, 32'h108, 1'b1);
    #1 chk("skid.rdy_no_comb", {31'b0, in_ready}, 32'd0);
    tick();
    chk_out("skid.out104", 1'b1, 32'h104, 1'b0);
    chk("skid.rdy_drained", {31'b0, in_ready}, 32'd1);
    tick();
    chk_out("skid.out108", 1'b1, 32'h108, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk_out("skid.empty", 1'b0, 32'h108, 1'b0);
    chk("skid.stall", {28'b0, stall_cnt}, 32'd3);
    drive(1'b0, 1'b1, 32'h180, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1 chk("skid.rdy_ordy0", {31'b0, in_ready}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    #1 chk("skid.rdy_ordy1", {31'b0, in_ready}, 32'd1);
    tick();
    chk_out("skid.drain180", 1'b0, 32'h180, 1'b0);
`else
    drive(1'b0, 1'b1, 32'h180, 1'b0);
    tick();
    chk_out("comb.m180", 1'b1, 32'h180, 1'b0);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1 chk("comb.rdy_ordy0", {31'b0, in_ready}, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    #1 chk("comb.rdy_ordy1", {31'b0, in_ready}, 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1 chk("comb.rdy_ordy0b", {31'b0, in_ready}, 32'd0);
    tick();
    chk("comb.stall", {28'b0, stall_cnt}, 32'd2);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    #1 chk("comb.rdy_ordy1b", {31'b0, in_ready}, 32'd1);
    tick();
    chk_out("comb.drain180", 1'b0, 32'h180, 1'b0);
`endif

    // stall counter saturation and immunity to flush
    drive(1'b0, 1'b1, 32'h300, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (20) tick();
    chk("sat.after20", {28'b0, stall_cnt}, 32'd15);
    repeat (5) tick();
    chk("sat.after25", {28'b0, stall_cnt}, 32'd15);
    chk_out("sat.hold300", 1'b1, 32'h300, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    chk("sat.flush", {28'b0, stall_cnt}, 32'd15);
    chk("sat.flush_valid", {31'b0, out_valid}, 32'd0);

    // asynchronous reset with storage full
    drive(1'b0, 1'b1, 32'h400, 1'b0);
    tick();
    drive(1'b0, 1'b1, 32'h404, 1'b0);
    tick();
    chk("mid.full", {31'b0, out_valid}, 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_reset_vals("mid.async");
    tick();
    chk_reset_vals("mid.next");
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    chk("mid.after_valid", {31'b0, out_valid}, 32'd0);
    chk("mid.after_pc", pc_out, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
